// File: rtl/audio_pkg.sv
// Shared audio definitions: playback FSM states, default sample pacing and
// small elaboration-time helpers used by the sound-effect player.
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_PACE  = 3'd4
  } sfx_state_t;

  // 50 MHz system clock divided down to a 48 kHz sample period.
  localparam int SFX_SAMPLE_DIV_DEFAULT = 32'sd1042;
  localparam int SAMPLE_WIDTH           = 32'sd16;

  // Counter/address width that never collapses to zero bits for tiny sizes.
  function automatic int clog2_min1(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/sfx_player_if.sv
// ROM fetch port and sample stream between the player (master) and the
// ROM/audio sink side (slave).
interface sfx_player_if #(
  parameter int ADDR_WIDTH = 13
);

  logic [ADDR_WIDTH-1:0] rom_address;
  logic [15:0]           rom_data;
  logic [15:0]           sample_data;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output rom_address,
    output sample_data,
    output sample_valid,
    input  rom_data,
    input  sample_ready
  );

  modport slave (
    input  rom_address,
    input  sample_data,
    input  sample_valid,
    output rom_data,
    output sample_ready
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running modulo-SAMPLE_DIV pacing counter; tick marks the last count
// of each sample period and the count restarts from zero on clear.
module sample_tick_gen
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = SFX_SAMPLE_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW       = clog2_min1(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          tick_r;

  // Next count: clear wins, otherwise wrap at the end of the period.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clear) begin
      cnt_next_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Count register; tick is registered from the next count so it lines up
  // with the cycle in which the count equals CNT_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == CNT_LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/sfx_player.sv
// Sound-effect player: walks an external synchronous ROM from sample 0 to
// DEPTH-1 and streams each sample over a valid/ready handshake at a paced rate.
module sfx_player
  import audio_pkg::*;
#(
  parameter int DEPTH      = 5000,
  parameter int ADDR_WIDTH = clog2_min1(DEPTH),
  parameter int SAMPLE_DIV = SFX_SAMPLE_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          trigger,
  sfx_player_if.master  bus,
  output logic          busy,
  output logic          done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 32'sd1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(32'sd1);

  sfx_state_t            state_r;
  sfx_state_t            state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           data_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pend_r;
  logic                  pend_next_s;
  logic                  restart_s;
  logic                  accept_s;
  logic                  last_s;
  logic                  tick_s;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (restart_s),
    .tick    (tick_s)
  );

  assign last_s = (addr_r == LAST_ADDR);

  // Next-state decode; a trigger restarts from any state, even on the
  // edge that would otherwise finish playback.
  always_comb begin
    state_next_s = state_r;
    restart_s    = 1'b0;
    accept_s     = 1'b0;
    if (trigger) begin
      state_next_s = ST_FETCH;
      restart_s    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = ST_IDLE;
        ST_FETCH: state_next_s = ST_LATCH;
        ST_LATCH: state_next_s = ST_HOLD;
        ST_HOLD: begin
          if (bus.sample_ready) begin
            accept_s     = 1'b1;
            state_next_s = last_s ? ST_IDLE : ST_PACE;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        ST_PACE: begin
          if (tick_s || pend_r) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_PACE;
          end
        end
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Remember at most one sample period that elapsed while a fetch or a
  // stalled sample was in flight, so the sink's stall does not skip a slot.
  always_comb begin
    pend_next_s = pend_r;
    if (restart_s || (state_next_s == ST_FETCH) || (state_next_s == ST_IDLE)) begin
      pend_next_s = 1'b0;
    end else if (tick_s && ((state_r == ST_FETCH) || (state_r == ST_LATCH) ||
                            (state_r == ST_HOLD))) begin
      pend_next_s = 1'b1;
    end else begin
      pend_next_s = pend_r;
    end
  end

  // State register and busy flag, both reflecting the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
    end
  end

  // Address, sample register, handshake and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r  <= '0;
      data_r  <= 16'h0000;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
      if (restart_s) begin
        addr_r  <= '0;
        valid_r <= 1'b0;
        done_r  <= 1'b0;
      end else if (accept_s) begin
        valid_r <= 1'b0;
        if (last_s) begin
          addr_r <= '0;
          done_r <= 1'b1;
        end else begin
          addr_r <= addr_r + ADDR_ONE;
          done_r <= 1'b0;
        end
      end else if (state_r == ST_LATCH) begin
        data_r  <= bus.rom_data;
        valid_r <= 1'b1;
        done_r  <= 1'b0;
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign bus.rom_address  = addr_r;
  assign bus.sample_data  = data_r;
  assign bus.sample_valid = valid_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule
